auv_irq_cond: RTL and testbench



---
 rtl/auv_irq_pkg.sv | 15 +
 rtl/auv_irq_sync.sv | 21 ++
 rtl/auv_irq_cond.sv | 141 ++++++++++++++
 tb/tb_auv_irq_cond.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/auv_irq_pkg.sv
// Shared definitions for the IRQ input conditioner: CSR register indices
// and the per-line presentation mode encoding.
package auv_irq_pkg;

    localparam logic [1:0] IRQC_MODE = 2'd0;
    localparam logic [1:0] IRQC_POL  = 2'd1;
    localparam logic [1:0] IRQC_PEND = 2'd2;
    localparam logic [1:0] IRQC_RAW  = 2'd3;

    typedef enum logic {
        IRQ_LEVEL = 1'b0,
        IRQ_EDGE  = 1'b1
    } irq_mode_e;

endpackage

// File: rtl/auv_irq_sync.sv
// Single-bit multi-flop synchroniser for an IRQ line asynchronous to clk.
module auv_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw line through the flop chain; the last flop is the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_chain <= '0;
        else        r_chain <= {r_chain[STAGES-2:0], i_d};
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/auv_irq_cond.sv
// Per-line IRQ conditioner: synchronise, optional glitch filter, polarity,
// then present each line as a level or as an edge-latched pending bit.
// Optional glitch filter enabled by defining AUV_IRQC_FILTER_EN.
module auv_irq_cond
    import auv_irq_pkg::*;
#(
    parameter int INT_COUNT     = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INT_COUNT-1:0] irq_pin,
    output logic [INT_COUNT-1:0] irq_out,
    input  logic                 cbus_sel,
    input  logic [1:0]           cbus_adr,
    input  logic [31:0]          cbus_dat_wr,
    output logic [31:0]          cbus_dat_rd,
    input  logic                 cbus_rd,
    input  logic                 cbus_wr,
    output logic                 cbus_ack
);

    if (INT_COUNT < 1 || INT_COUNT > 32 || SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_param
        $error("auv_irq_cond: parameter out of range");
    end

    logic [INT_COUNT-1:0] w_sync, w_filt, w_cond, w_rise, w_w1c, w_mode_nxt, w_wdat;
    logic [INT_COUNT-1:0] r_mode, r_pol, r_prev, r_level, r_pend;
    logic                 w_rd, w_wr, w_valid;
    logic [31:0]          w_rdata;
    logic                 r_ack;
    logic [31:0]          r_dat_rd;
    logic                 w_unused_wr;

    for (genvar gi = 0; gi < INT_COUNT; gi++) begin : g_line
        auv_irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .i_d   (irq_pin[gi]),
            .o_q   (w_sync[gi])
        );
        assign irq_out[gi] = (irq_mode_e'(r_mode[gi]) == IRQ_EDGE) ? r_pend[gi] : r_level[gi];
    end

`ifdef AUV_IRQC_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    logic [INT_COUNT-1:0][CW-1:0] r_fcnt;
    logic [INT_COUNT-1:0]         r_filt;

    // Accept a new sync value only after it has differed from filt for
    // FILTER_CYCLES consecutive cycles; the update happens on the cycle
    // the count would reach FILTER_CYCLES, so shorter pulses never land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
            r_filt <= '0;
        end else begin
            for (int i = 0; i < INT_COUNT; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == CW'(FILTER_CYCLES - 1)) begin
                    r_filt[i] <= w_sync[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = w_sync;
`endif

    assign w_cond = w_filt ^ r_pol;
    assign w_rise = w_cond & ~r_prev;

    // Bus decode: a read wins over a simultaneous write; RAW is read-only
    // so a write there is neither acknowledged nor acted on.
    assign w_rd        = cbus_sel & cbus_rd;
    assign w_wr        = cbus_sel & cbus_wr & ~cbus_rd;
    assign w_valid     = w_rd | (w_wr & (cbus_adr != IRQC_RAW));
    assign w_wdat      = cbus_dat_wr[INT_COUNT-1:0];
    assign w_mode_nxt  = (w_wr && cbus_adr == IRQC_MODE) ? w_wdat : r_mode;
    assign w_w1c       = (w_wr && cbus_adr == IRQC_PEND) ? w_wdat : '0;
    assign w_unused_wr = ^cbus_dat_wr;

    // Read-data mux, unused upper bits zero.
    always_comb begin
        w_rdata = '0;
        case (cbus_adr)
            IRQC_MODE: w_rdata[INT_COUNT-1:0] = r_mode;
            IRQC_POL:  w_rdata[INT_COUNT-1:0] = r_pol;
            IRQC_PEND: w_rdata[INT_COUNT-1:0] = irq_out;
            default:   w_rdata[INT_COUNT-1:0] = w_sync;
        endcase
    end

    // Configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= '0;
            r_pol  <= '0;
        end else begin
            r_mode <= w_mode_nxt;
            if (w_wr && cbus_adr == IRQC_POL) r_pol <= w_wdat;
        end
    end

    // Line state: level/prev track cond every cycle; pending is gated by the
    // next mode so leaving edge mode clears it on the same edge, and a rise
    // beats a coincident W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_prev  <= '0;
            r_pend  <= '0;
        end else begin
            r_level <= w_cond;
            r_prev  <= w_cond;
            r_pend  <= w_mode_nxt & ((r_pend & ~w_w1c) | w_rise);
        end
    end

    // Bus response: one-cycle ack; read data held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack    <= 1'b0;
            r_dat_rd <= '0;
        end else begin
            r_ack <= w_valid;
            if (w_rd) r_dat_rd <= w_rdata;
        end
    end

    assign cbus_ack    = r_ack;
    assign cbus_dat_rd = r_dat_rd;

endmodule

// File: tb/tb_auv_irq_cond.sv
// Self-checking bench for auv_irq_cond: level-mode vector table plus
// hand-written edge/W1C/mode/polarity/reset sequences.
module tb_auv_irq_cond;
    import auv_irq_pkg::*;

    localparam int N = 16;
`ifdef AUV_IRQC_FILTER_EN
    localparam int LAT = 3 + 4;
    localparam int PW  = 5;
`else
    localparam int LAT = 3;
    localparam int PW  = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] irq_pin = '0;
    logic [N-1:0] irq_out;
    logic         cbus_sel = 1'b0;
    logic [1:0]   cbus_adr = '0;
    logic [31:0]  cbus_dat_wr = '0;
    logic [31:0]  cbus_dat_rd;
    logic         cbus_rd = 1'b0;
    logic         cbus_wr = 1'b0;
    logic         cbus_ack;

    always #5 clk = ~clk;

    auv_irq_cond #(.INT_COUNT(N), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_pin     (irq_pin),
        .irq_out     (irq_out),
        .cbus_sel    (cbus_sel),
        .cbus_adr    (cbus_adr),
        .cbus_dat_wr (cbus_dat_wr),
        .cbus_dat_rd (cbus_dat_rd),
        .cbus_rd     (cbus_rd),
        .cbus_wr     (cbus_wr),
        .cbus_ack    (cbus_ack)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [N-1:0] pol;
        logic [N-1:0] pin;
        logic [N-1:0] exp;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Read: expected data queued at request, popped when the ack cycle arrives.
    task automatic bus_rd(input logic [1:0] adr, input logic [31:0] exp, input string name);
        cbus_sel = 1'b1; cbus_rd = 1'b1; cbus_wr = 1'b0; cbus_adr = adr;
        sb_q.push_back(exp);
        @(negedge clk);
        cbus_sel = 1'b0; cbus_rd = 1'b0;
        chk({name, "_ack"}, 32'(cbus_ack), 32'd1);
        chk(name, cbus_dat_rd, sb_q.pop_front());
    endtask

    task automatic bus_wr(input logic [1:0] adr, input logic [31:0] dat, input logic exp_ack,
                          input string name);
        cbus_sel = 1'b1; cbus_wr = 1'b1; cbus_rd = 1'b0; cbus_adr = adr; cbus_dat_wr = dat;
        @(negedge clk);
        cbus_sel = 1'b0; cbus_wr = 1'b0;
        chk({name, "_ack"}, 32'(cbus_ack), 32'(exp_ack));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h0000, 16'h0001, 16'h0001};
        tbl[1] = '{16'h0000, 16'h0000, 16'h0000};
        tbl[2] = '{16'h0004, 16'h0000, 16'h0004};
        tbl[3] = '{16'h0004, 16'h0004, 16'h0000};
        tbl[4] = '{16'hFFFF, 16'h0000, 16'hFFFF};
        tbl[5] = '{16'h00F0, 16'hA5A5, 16'hA555};
        tbl[6] = '{16'h0000, 16'h8000, 16'h8000};
        tbl[7] = '{16'hFFFF, 16'hFFFF, 16'h0000};

        // Reset state.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_irq_out", 32'(irq_out), 32'h0);
        chk("rst_ack", 32'(cbus_ack), 32'h0);
        chk("rst_dat_rd", cbus_dat_rd, 32'h0);
        wait_n(2);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rd(IRQC_MODE, 32'h0, "rst_mode");
        bus_rd(IRQC_POL,  32'h0, "rst_pol");
        bus_rd(IRQC_PEND, 32'h0, "rst_pend");

        // Level-mode latency, rising and falling.
        irq_pin = 16'h0001;
        wait_n(LAT - 1); chk("lvl_rise_early", 32'(irq_out), 32'h0);
        wait_n(1);       chk("lvl_rise", 32'(irq_out), 32'h1);
        irq_pin = 16'h0000;
        wait_n(LAT - 1); chk("lvl_fall_early", 32'(irq_out), 32'h1);
        wait_n(1);       chk("lvl_fall", 32'(irq_out), 32'h0);

        // Level-mode polarity/pin table.
        for (int v = 0; v < 8; v++) begin
            irq_pin = tbl[v].pin;
            bus_wr(IRQC_MODE, 32'h0, 1'b1, "tbl_mode_wr");
            bus_wr(IRQC_POL, 32'(tbl[v].pol), 1'b1, "tbl_pol_wr");
            wait_n(LAT);
            chk($sformatf("tbl%0d_out", v), 32'(irq_out), 32'(tbl[v].exp));
            bus_rd(IRQC_PEND, 32'(tbl[v].exp), $sformatf("tbl%0d_pend", v));
            bus_rd(IRQC_RAW,  32'(tbl[v].pin), $sformatf("tbl%0d_raw", v));
        end
        bus_wr(IRQC_POL, 32'h0, 1'b1, "pol_clr");
        irq_pin = '0;
        wait_n(LAT + 1);

        // Edge mode: short pulse latches and holds until W1C.
        bus_wr(IRQC_MODE, 32'h2, 1'b1, "edge_mode_wr");
        irq_pin = 16'h0002;
        wait_n(PW);
        irq_pin = 16'h0000;
        wait_n(LAT - PW); chk("edge_set", 32'(irq_out), 32'h2);
        wait_n(4);        chk("edge_hold", 32'(irq_out), 32'h2);
        bus_rd(IRQC_PEND, 32'h2, "edge_pend_rd");
        bus_wr(IRQC_PEND, 32'h2, 1'b1, "edge_w1c");
        chk("edge_w1c_out", 32'(irq_out), 32'h0);

        // W1C coincident with the rise: set wins.
        irq_pin = 16'h0002;
        wait_n(LAT - 1);
        bus_wr(IRQC_PEND, 32'h2, 1'b1, "same_w1c");
        chk("same_set_wins", 32'(irq_out), 32'h2);
        irq_pin = 16'h0000;
        wait_n(LAT + 1);
        bus_wr(IRQC_PEND, 32'h2, 1'b1, "same_cleanup");
        chk("same_cleanup_out", 32'(irq_out), 32'h0);

        // W1C one cycle after the rise: cleared, no re-set while line stays high.
        irq_pin = 16'h0002;
        wait_n(LAT);
        chk("late_set", 32'(irq_out), 32'h2);
        bus_wr(IRQC_PEND, 32'h2, 1'b1, "late_w1c");
        chk("late_cleared", 32'(irq_out), 32'h0);

        // MODE 0->1 while the line is already asserted: no pending.
        bus_wr(IRQC_MODE, 32'h0, 1'b1, "m01_lvl");
        chk("m01_level_view", 32'(irq_out), 32'h2);
        bus_wr(IRQC_MODE, 32'h2, 1'b1, "m01_edge");
        chk("m01_nopend", 32'(irq_out), 32'h0);
        wait_n(2);
        chk("m01_nopend_later", 32'(irq_out), 32'h0);

        // MODE 1->0 clears pending (line low, so level view is 0 too).
        irq_pin = 16'h0000;
        wait_n(LAT);
        irq_pin = 16'h0002;
        wait_n(LAT);
        irq_pin = 16'h0000;
        wait_n(LAT + 1);
        chk("m10_pend_before", 32'(irq_out), 32'h2);
        bus_wr(IRQC_MODE, 32'h0, 1'b1, "m10_lvl");
        chk("m10_cleared", 32'(irq_out), 32'h0);
        bus_wr(IRQC_MODE, 32'h2, 1'b1, "m10_edge");
        chk("m10_stays_clear", 32'(irq_out), 32'h0);
        bus_rd(IRQC_MODE, 32'h2, "mode_rd");
        bus_wr(IRQC_MODE, 32'h0, 1'b1, "mode_lvl");
        chk("dat_rd_hold", cbus_dat_rd, 32'h2);

        // Active-low line, RAW readback, write to RAW not acknowledged.
        bus_wr(IRQC_POL, 32'h4, 1'b1, "pol4_wr");
        wait_n(2);
        chk("pol4_out", 32'(irq_out), 32'h4);
        bus_rd(IRQC_RAW, 32'h0, "raw_rd");
        bus_wr(IRQC_RAW, 32'hFFFF_FFFF, 1'b0, "raw_wr");
        wait_n(1);
        chk("raw_wr_no_ack_late", 32'(cbus_ack), 32'h0);
        bus_rd(IRQC_POL,  32'h4, "pol_after_raw_wr");
        bus_rd(IRQC_MODE, 32'h0, "mode_after_raw_wr");

        // Read and write together: read wins, no write.
        cbus_sel = 1'b1; cbus_rd = 1'b1; cbus_wr = 1'b1;
        cbus_adr = IRQC_MODE; cbus_dat_wr = 32'hFFFF_FFFF;
        sb_q.push_back(32'h0);
        @(negedge clk);
        cbus_sel = 1'b0; cbus_rd = 1'b0; cbus_wr = 1'b0;
        chk("rdwr_ack", 32'(cbus_ack), 32'h1);
        chk("rdwr_data", cbus_dat_rd, sb_q.pop_front());
        bus_rd(IRQC_MODE, 32'h0, "rdwr_mode_unchanged");

        // Reset mid-operation with all lines asserted.
        bus_wr(IRQC_POL, 32'hFFFF_FFFF, 1'b1, "allhi_pol");
        wait_n(2);
        chk("allhi_out", 32'(irq_out), 32'hFFFF);
        bus_rd(IRQC_POL, 32'hFFFF, "allhi_pol_rd");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", 32'(irq_out), 32'h0);
        chk("midrst_dat_rd", cbus_dat_rd, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rd(IRQC_MODE, 32'h0, "post_rst_mode");
        bus_rd(IRQC_POL,  32'h0, "post_rst_pol");
        bus_rd(IRQC_PEND, 32'h0, "post_rst_pend");
        bus_rd(IRQC_RAW,  32'h0, "post_rst_raw");

`ifdef AUV_IRQC_FILTER_EN
        // Glitch filter: 3-cycle pulse dropped, 5-cycle pulse passes.
        irq_pin = 16'h0001;
        wait_n(3);
        irq_pin = 16'h0000;
        for (int c = 0; c < 12; c++) begin
            wait_n(1);
            chk("filt_short", 32'(irq_out), 32'h0);
        end
        irq_pin = 16'h0001;
        wait_n(5);
        irq_pin = 16'h0000;
        wait_n(1); chk("filt_long_early", 32'(irq_out), 32'h0);
        wait_n(1); chk("filt_long", 32'(irq_out), 32'h1);
        wait_n(12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
